sprite_hit_pipeline: RTL and testbench

Multi-sprite, pipelined successor of the single-sprite hit test. It checks each screen pixel (x, y with y pointing down) against NUM_SPRITES sprite rectangles and reports the highest-priority hit, with that sprite's linear texel index, 3 cycles later. Sprite descriptors are double-buffered and committed on frame_sync, so the renderer never sees a partially updated sprite table mid-frame. It sits between the VGA pixel counter and the sprite ROM/colour mux.

---
 rtl/sprite_hit_pipeline.sv | 192 +++++++++++++++++++
 tb/tb_sprite_hit_pipeline.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_hit_pipeline.sv
// Three-stage multi-sprite hit test: per-pixel rectangle compare, priority pick,
// texel index. Sprite descriptors are double-buffered and committed on frame_sync.
module sprite_hit_pipeline #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 19,
   parameter int IDX_W       = 19,
   parameter int SCREEN_H    = 480,
   localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COORD_W-1:0]     in_x,
   input  logic [COORD_W-1:0]     in_y,
   input  logic                   cfg_we,
   input  logic [SEL_W-1:0]       cfg_sel,
   input  logic [63:0]            cfg_data,
   input  logic                   cfg_en,
   input  logic                   frame_sync,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_hit,
   output logic [SEL_W-1:0]       out_sprite,
   output logic [IDX_W-1:0]       out_index,
   output logic [NUM_SPRITES-1:0] out_mask
);

   localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);

   // Descriptor field order inside cfg_data: 3 = blX, 2 = blY, 1 = width, 0 = height.
   function automatic logic [COORD_W-1:0] field(input logic [63:0] d, input int sel);
      return COORD_W'(d[sel*16 +: 16]);
   endfunction

   function automatic logic in_rect(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] ty,
                                    input logic [COORD_W-1:0] bl_x,
                                    input logic [COORD_W-1:0] bl_y,
                                    input logic [COORD_W-1:0] top_x,
                                    input logic [COORD_W-1:0] top_y);
      return (x > bl_x) && (x < top_x) && (ty > bl_y) && (ty < top_y);
   endfunction

   function automatic logic [IDX_W-1:0] calc_index(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [COORD_W-1:0] bl_x,
                                                   input logic [COORD_W-1:0] top_y,
                                                   input logic [COORD_W-1:0] width);
      logic [COORD_W-1:0] dx;
      logic [COORD_W-1:0] dy;
      dx = x - bl_x;
      dy = y - (SCREEN_H_C - top_y);
      return IDX_W'(dx) + IDX_W'(dy) * IDX_W'(width);
   endfunction

   logic [63:0]            shadow_data     [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] shadow_en;
   logic [63:0]            shadow_data_nxt [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] shadow_en_nxt;
   logic [63:0]            active_data     [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] active_en;

   // A write in the same cycle as frame_sync must land in the committed table.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_data_nxt[i] = shadow_data[i];
         shadow_en_nxt[i]   = shadow_en[i];
         if (cfg_we && (cfg_sel == SEL_W'(i))) begin
            shadow_data_nxt[i] = cfg_data;
            shadow_en_nxt[i]   = cfg_en;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_data[i] <= '0;
            active_data[i] <= '0;
         end
         shadow_en <= '0;
         active_en <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_data[i] <= shadow_data_nxt[i];
            if (frame_sync) active_data[i] <= shadow_data_nxt[i];
         end
         shadow_en <= shadow_en_nxt;
         if (frame_sync) active_en <= shadow_en_nxt;
      end
   end

   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // ---- stage 1: rectangle compare against the active table ----
   logic [COORD_W-1:0]     trans_y;
   logic [COORD_W-1:0]     s1_bl_x  [NUM_SPRITES];
   logic [COORD_W-1:0]     s1_top_y [NUM_SPRITES];
   logic [COORD_W-1:0]     s1_width [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] s1_hit;

   always_comb begin
      trans_y = SCREEN_H_C - in_y;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         s1_bl_x[i]  = field(active_data[i], 3);
         s1_width[i] = field(active_data[i], 1);
         s1_top_y[i] = field(active_data[i], 2) + field(active_data[i], 0);
         s1_hit[i]   = active_en[i] &&
                       in_rect(in_x, trans_y, s1_bl_x[i], field(active_data[i], 2),
                               s1_bl_x[i] + s1_width[i], s1_top_y[i]);
      end
   end

   logic                   vld_p0;
   logic [COORD_W-1:0]     x_p0;
   logic [COORD_W-1:0]     y_p0;
   logic [NUM_SPRITES-1:0] mask_p0;
   logic [COORD_W-1:0]     bl_x_p0  [NUM_SPRITES];
   logic [COORD_W-1:0]     top_y_p0 [NUM_SPRITES];
   logic [COORD_W-1:0]     width_p0 [NUM_SPRITES];

   always_ff @(posedge clock) begin
      if (advance) begin
         x_p0    <= in_x;
         y_p0    <= in_y;
         mask_p0 <= s1_hit;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            bl_x_p0[i]  <= s1_bl_x[i];
            top_y_p0[i] <= s1_top_y[i];
            width_p0[i] <= s1_width[i];
         end
      end
   end

   // ---- stage 2: priority select, slot 0 wins ----
   logic [SEL_W-1:0] win_sel;

   always_comb begin
      win_sel = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (mask_p0[i]) win_sel = SEL_W'(i);
      end
   end

   logic                   vld_p1;
   logic                   any_p1;
   logic [SEL_W-1:0]       win_p1;
   logic [NUM_SPRITES-1:0] mask_p1;
   logic [COORD_W-1:0]     x_p1;
   logic [COORD_W-1:0]     y_p1;
   logic [COORD_W-1:0]     bl_x_p1;
   logic [COORD_W-1:0]     top_y_p1;
   logic [COORD_W-1:0]     width_p1;

   always_ff @(posedge clock) begin
      if (advance) begin
         any_p1   <= |mask_p0;
         win_p1   <= win_sel;
         mask_p1  <= mask_p0;
         x_p1     <= x_p0;
         y_p1     <= y_p0;
         bl_x_p1  <= bl_x_p0[win_sel];
         top_y_p1 <= top_y_p0[win_sel];
         width_p1 <= width_p0[win_sel];
      end
   end

   // ---- stage 3: texel index and output register ----
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         out_valid  <= 1'b0;
         out_hit    <= 1'b0;
         out_sprite <= '0;
         out_index  <= '0;
         out_mask   <= '0;
      end else if (advance) begin
         vld_p0     <= in_valid;
         vld_p1     <= vld_p0;
         out_valid  <= vld_p1;
         out_hit    <= any_p1;
         out_sprite <= any_p1 ? win_p1 : '0;
         out_index  <= any_p1 ? calc_index(x_p1, y_p1, bl_x_p1, top_y_p1, width_p1) : '0;
         out_mask   <= mask_p1;
      end
   end

endmodule

// File: tb/tb_sprite_hit_pipeline.sv
// Scoreboard bench for sprite_hit_pipeline: directed pixels with hand-computed
// results, checked by an independent output monitor.
module tb_sprite_hit_pipeline;

   localparam int NS = 4;
   localparam int CW = 19;
   localparam int IW = 19;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_x;
   logic [CW-1:0] in_y;
   logic          cfg_we;
   logic [1:0]    cfg_sel;
   logic [63:0]   cfg_data;
   logic          cfg_en;
   logic          frame_sync;
   logic          out_valid;
   logic          out_ready;
   logic          out_hit;
   logic [1:0]    out_sprite;
   logic [IW-1:0] out_index;
   logic [NS-1:0] out_mask;

   sprite_hit_pipeline #(.NUM_SPRITES(NS), .COORD_W(CW), .IDX_W(IW), .SCREEN_H(480)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .cfg_en(cfg_en), .frame_sync(frame_sync),
      .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
      .out_sprite(out_sprite), .out_index(out_index), .out_mask(out_mask)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic          hit;
      logic [1:0]    spr;
      logic [IW-1:0] idx;
      logic [NS-1:0] mask;
      int            req_cyc;
      bit            chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: pops one expectation per delivered result, checks hold during stalls.
   initial begin
      exp_t          e;
      bit            stall_prev = 0;
      logic          s_hit;
      logic [1:0]    s_spr;
      logic [IW-1:0] s_idx;
      logic [NS-1:0] s_mask;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall_prev = 0;
         end else begin
            if (stall_prev) begin
               chk("held_valid", 32'(out_valid), 32'd1);
               chk("held_data", {out_hit, out_sprite, out_index, out_mask},
                   {s_hit, s_spr, s_idx, s_mask});
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: got index %0d, expected no result", out_index);
               end else begin
                  e = sb.pop_front();
                  chk("out_hit", 32'(out_hit), 32'(e.hit));
                  chk("out_sprite", 32'(out_sprite), 32'(e.spr));
                  chk("out_index", 32'(out_index), 32'(e.idx));
                  chk("out_mask", 32'(out_mask), 32'(e.mask));
                  if (e.chk_lat) chk("latency", 32'(cyc - e.req_cyc), 32'd3);
               end
            end
            stall_prev = out_valid && !out_ready;
            s_hit = out_hit; s_spr = out_sprite; s_idx = out_index; s_mask = out_mask;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic h, input int spr, input int idx,
                           input logic [NS-1:0] m, input bit lat);
      exp_t e;
      e.hit = h; e.spr = 2'(spr); e.idx = IW'(idx); e.mask = m;
      e.req_cyc = cyc; e.chk_lat = lat;
      sb.push_back(e);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int x, input int y, input logic h, input int spr,
                       input int idx, input logic [NS-1:0] m, input bit lat);
      int t = 0;
      in_valid = 1'b1;
      in_x = CW'(x);
      in_y = CW'(y);
      @(negedge clock);
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      else push_exp(h, spr, idx, m, lat);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic cfg(input bit we, input int sel, input int bx, input int by,
                      input int w, input int ht, input logic en, input bit sync);
      cfg_we     = we;
      cfg_sel    = 2'(sel);
      cfg_data   = {16'(bx), 16'(by), 16'(w), 16'(ht)};
      cfg_en     = en;
      frame_sync = sync;
      tick();
      cfg_we     = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int px[5]   = '{111, 112, 113, 114, 115};
      int py[5]   = '{369, 368, 367, 366, 365};
      int pidx[5] = '{91, 82, 73, 64, 55};
      int sent;

      reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
      cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; cfg_en = 1'b0;
      frame_sync = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outputs", {out_hit, out_sprite, out_index, out_mask}, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Single sprite; write and commit in the same cycle.
      cfg(1, 0, 100, 100, 50, 40, 1'b1, 1);
      send(120, 360, 1'b1, 0, 1020, 4'b0001, 1);
      drain();

      // Edge pixels are outside; one interior corner pixel inside.
      send(100, 360, 1'b0, 0, 0, 4'b0000, 1);
      send(150, 360, 1'b0, 0, 0, 4'b0000, 1);
      send(120, 380, 1'b0, 0, 0, 4'b0000, 1);
      send(149, 341, 1'b1, 0, 99, 4'b0001, 1);
      drain();

      // Priority between overlapping sprites.
      cfg(1, 1, 110, 110, 10, 10, 1'b1, 0);
      cfg(0, 0, 0, 0, 0, 0, 1'b0, 1);
      send(115, 365, 1'b1, 0, 1265, 4'b0011, 1);
      drain();
      cfg(1, 0, 100, 100, 50, 40, 1'b0, 1);
      send(115, 365, 1'b1, 1, 55, 4'b0010, 1);
      drain();

      // Double buffering: shadow write is invisible until frame_sync.
      cfg(1, 0, 100, 100, 50, 40, 1'b1, 1);
      cfg(1, 0, 0, 0, 0, 0, 1'b1, 0);
      send(120, 360, 1'b1, 0, 1020, 4'b0001, 1);
      send(120, 360, 1'b1, 0, 1020, 4'b0001, 1);
      cfg(0, 0, 0, 0, 0, 0, 1'b0, 1);
      send(120, 360, 1'b0, 0, 0, 4'b0000, 1);
      drain();

      // Backpressure: five pixels inside slot 1, out_ready low for cycles 4-6.
      sent = 0;
      for (int k = 0; k < 30 && sent < 5; k++) begin
         out_ready = !(k >= 4 && k <= 6);
         in_valid  = 1'b1;
         in_x      = CW'(px[sent]);
         in_y      = CW'(py[sent]);
         @(negedge clock);
         if (k >= 4 && k <= 6) chk("stall_in_ready", 32'(in_ready), 32'd0);
         if (in_ready) begin
            push_exp(1'b1, 1, pidx[sent], 4'b0010, 0);
            sent++;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream_sent", 32'(sent), 32'd5);
      drain();

      // Reset with two pixels in flight.
      send(115, 365, 1'b1, 1, 55, 4'b0010, 0);
      send(112, 368, 1'b1, 1, 82, 4'b0010, 0);
      reset = 1'b1;
      tick();
      sb.delete();
      @(negedge clock);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
      tick();
      send(115, 365, 1'b0, 0, 0, 4'b0000, 1);
      send(120, 360, 1'b0, 0, 0, 4'b0000, 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
